bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, sets the width of the address paths.
REQ-002 Parameter DATA_W, default 64, sets the width of the data paths.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 m0_req  in  1  instruction-fetch read request, held until m0_gnt.
REQ-006 m0_addr  in  ADDR_W  fetch read address.
REQ-007 m0_kill  in  1  fetch redirect: discard any outstanding m0 response.
REQ-008 m0_gnt  out  1  one-cycle pulse when the m0 A beat is accepted.
REQ-009 m0_rvalid  out  1  one-cycle pulse when rdata holds the m0 response.
REQ-010 m1_req  in  1  data-port request, held until m1_gnt.
REQ-011 m1_we  in  1  1 selects write (PutFullData), 0 selects read (Get).
REQ-012 m1_addr  in  ADDR_W  data-port address.
REQ-013 m1_wdata  in  DATA_W  data-port write data.
REQ-014 m1_gnt  out  1  one-cycle pulse when the m1 A beat is accepted.
REQ-015 m1_rvalid  out  1  one-cycle pulse when the m1 response (read data or write ack) is ready.
REQ-016 rdata  out  DATA_W  registered response data, shared by both masters.
REQ-017 bus_a_valid  out  1  TileLink A-channel valid.
REQ-018 bus_a_ready  in  1  TileLink A-channel ready.
REQ-019 bus_a_opcode  out  3  Get=4, PutFullData=0.
REQ-020 bus_a_address  out  ADDR_W  A-channel address.
REQ-021 bus_a_data  out  DATA_W  A-channel data; zero for Get.
REQ-022 bus_d_valid  in  1  TileLink D-channel valid.
REQ-023 bus_d_ready  out  1  TileLink D-channel ready.
REQ-024 bus_d_data  in  DATA_W  D-channel data.
REQ-025 busy  out  1  1 whenever state is not IDLE.

Function
REQ-026 The FSM SHALL have states IDLE, REQ, RESP, with exactly one transaction outstanding at a time.
REQ-027 IDLE: if any req is 1, the arbiter SHALL pick an owner, capture its opcode/address/data into registers, and go to REQ on the next edge.
REQ-028 Tie (both req): the arbiter SHALL grant the master not granted last (round-robin); a single requester always wins.
REQ-029 REQ: bus_a_valid SHALL be 1 and A fields SHALL be stable until bus_a_ready is 1.
REQ-030 On an A handshake, the owner's gnt SHALL pulse in that same cycle and the next state SHALL be RESP.
REQ-031 RESP: bus_d_ready SHALL be 1; on bus_d_valid, rdata SHALL register bus_d_data, the owner's rvalid SHALL pulse in the next cycle, and the state SHALL return to IDLE.
REQ-032 Minimum request-to-rvalid latency SHALL be 4 cycles (IDLE sample, A beat, D beat, rvalid), with A and D ready/valid at first opportunity.
REQ-033 A new request SHALL be sampled in IDLE on the same cycle that rvalid pulses, giving back-to-back throughput of 3 cycles per transaction.
REQ-034 m0_kill asserted while m0 owns REQ or RESP SHALL set a drop flag, so the transaction completes on the bus but m0_rvalid is suppressed.
REQ-035 m0_kill in IDLE or with m1 as owner SHALL have no effect; the drop flag SHALL clear on return to IDLE.
REQ-036 Deassertion of req before gnt is a protocol violation; the captured transaction SHALL still complete.
REQ-037 bus_a_valid and bus_d_ready SHALL never be 1 in the same cycle.

Reset
REQ-038 While rst_n=0, the block SHALL force state IDLE, with all gnt/rvalid/bus_a_valid/bus_d_ready/busy = 0, rdata = 0, A fields = 0, and the drop flag = 0.
REQ-039 Last-granted SHALL reset to m1, so m0 wins the first tie.
REQ-040 Reset asserted mid-transaction SHALL abandon the transaction; no rvalid SHALL follow reset release.

Verification
REQ-041 Both masters request at cycle 0 from reset, with ready/valid immediate: m0 Get 0x8000_0000 gets m0_gnt at cycle 1 and m0_rvalid at cycle 3; m1 is then granted at cycle 4.
REQ-042 m1 write 0x8000_1000 with wdata 0xDEAD_BEEF: the A beat carries opcode 0, address 0x8000_1000, data 0xDEAD_BEEF, and m1_rvalid pulses after the D beat.
REQ-043 bus_a_ready held 0 for 5 cycles: bus_a_valid and the address stay constant, and gnt pulses exactly once, when ready rises.
REQ-044 m0_kill pulsed during m0 RESP: the D beat is consumed (bus_d_ready=1), m0_rvalid stays 0, and the next m0 request completes normally.
REQ-045 rst_n dropped during RESP, then released: outputs are 0 immediately, busy=0, and no rvalid appears after release.
REQ-046 Continuous dual requests over 10 transactions: grants alternate m0, m1, m0, …, with no A-channel overlap.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
// TileLink-UL style A/D channel bundle between the two-master arbiter and the
// downstream memory port.
//
//   a_valid    A-channel request valid          (master -> slave)
//   a_ready    A-channel ready                  (slave  -> master)
//   a_opcode   Get = 4, PutFullData = 0         (master -> slave)
//   a_address  request address                  (master -> slave)
//   a_data     write data, zero for Get         (master -> slave)
//   d_valid    D-channel response valid         (slave  -> master)
//   d_ready    D-channel ready                  (master -> slave)
//   d_data     response data                    (slave  -> master)
// ---------------------------------------------------------------------------
interface bus_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              a_valid;
   logic              a_ready;
   logic [2:0]        a_opcode;
   logic [ADDR_W-1:0] a_address;
   logic [DATA_W-1:0] a_data;
   logic              d_valid;
   logic              d_ready;
   logic [DATA_W-1:0] d_data;

   modport master (
      output a_valid,
      output a_opcode,
      output a_address,
      output a_data,
      output d_ready,
      input  a_ready,
      input  d_valid,
      input  d_data
   );

   modport slave (
      input  a_valid,
      input  a_opcode,
      input  a_address,
      input  a_data,
      input  d_ready,
      output a_ready,
      output d_valid,
      output d_data
   );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master arbiter in front of a single TileLink-UL port. m0 is an
// instruction-fetch read port with a redirect (kill) input, m1 is a data port
// that can read or write. Exactly one transaction is outstanding at a time.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   m0_req/m0_addr    fetch read request, held until m0_gnt
//   m0_kill           drop any outstanding m0 response
//   m0_gnt/m0_rvalid  A-beat accepted / response in rdata (one-cycle pulses)
//   m1_req/m1_we      data-port request, 1 = write (PutFullData), 0 = read
//   m1_addr/m1_wdata  data-port address / write data
//   m1_gnt/m1_rvalid  A-beat accepted / response ready (one-cycle pulses)
//   rdata             registered response data shared by both masters
//   busy              1 whenever the FSM is not IDLE
//   bus               A/D channels to the memory side (master modport)
//
// State   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; requests sampled, owner picked and captured
// REQ     | A beat presented, held stable until a_ready
// RESP    | waiting for the D beat; rdata captured on d_valid
// ---------------------------------------------------------------------------
module bus_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_kill,
   output logic              m0_gnt,
   output logic              m0_rvalid,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,

   output logic [DATA_W-1:0] rdata,
   output logic              busy,

   bus_arbiter_if.master     bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] OP_GET = 3'd4;
   localparam logic [2:0] OP_PUT = 3'd0;

   state_t            state_q;
   state_t            state_d;

   // owner/last encoding: 0 = m0, 1 = m1
   logic              owner_q;
   logic              last_q;
   logic              pick;
   logic              take;

   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   logic              drop_q;
   logic              rvalid0_q;
   logic              rvalid1_q;

   logic              a_fire;
   logic              d_fire;
   logic              kill_hit;

   // ---------------------------------------------------------------------
   // Arbitration: a lone requester wins; on a tie the master not granted
   // last time wins.
   // ---------------------------------------------------------------------
   always_comb begin
      take = m0_req | m1_req;
      pick = 1'b0;
      if (m0_req && m1_req) begin
         pick = ~last_q;
      end else begin
         pick = m1_req;
      end
   end

   assign a_fire   = (state_q == REQ)  && bus.a_ready;
   assign d_fire   = (state_q == RESP) && bus.d_valid;
   assign kill_hit = m0_kill && !owner_q && (state_q != IDLE);

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (take) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.a_ready) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.d_valid) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output logic. Channel handshakes are pure functions of the state so
   // a_valid and d_ready can never overlap.
   // ---------------------------------------------------------------------
   always_comb begin
      bus.a_valid = 1'b0;
      bus.d_ready = 1'b0;
      busy        = 1'b0;
      m0_gnt      = 1'b0;
      m1_gnt      = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
         end
         REQ: begin
            busy        = 1'b1;
            bus.a_valid = 1'b1;
            m0_gnt      = a_fire && !owner_q;
            m1_gnt      = a_fire &&  owner_q;
         end
         RESP: begin
            busy        = 1'b1;
            bus.d_ready = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign bus.a_opcode  = op_q;
   assign bus.a_address = addr_q;
   assign bus.a_data    = data_q;
   assign m0_rvalid     = rvalid0_q;
   assign m1_rvalid     = rvalid1_q;

   // ---------------------------------------------------------------------
   // Transaction capture. Fields are loaded only in IDLE so they stay
   // stable through REQ even if the requester drops req early.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         op_q    <= 3'd0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if ((state_q == IDLE) && take) begin
         owner_q <= pick;
         last_q  <= pick;
         if (pick) begin
            op_q   <= m1_we ? OP_PUT : OP_GET;
            addr_q <= m1_addr;
            data_q <= m1_we ? m1_wdata : '0;
         end else begin
            op_q   <= OP_GET;
            addr_q <= m0_addr;
            data_q <= '0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Response path. A kill arriving in the same cycle as the D beat must
   // also suppress rvalid, hence kill_hit alongside drop_q.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata     <= '0;
      end else begin
         if (state_d == IDLE) begin
            drop_q <= 1'b0;
         end else if (kill_hit) begin
            drop_q <= 1'b1;
         end
         rvalid0_q <= d_fire && !owner_q && !drop_q && !kill_hit;
         rvalid1_q <= d_fire && owner_q;
         if (d_fire) begin
            rdata <= bus.d_data;
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter. Inputs change 1 ns after the rising edge;
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          m0_req   = 1'b0;
   logic          m0_kill  = 1'b0;
   logic [AW-1:0] m0_addr  = '0;
   logic          m1_req   = 1'b0;
   logic          m1_we    = 1'b0;
   logic [AW-1:0] m1_addr  = '0;
   logic [DW-1:0] m1_wdata = '0;
   logic          m0_gnt;
   logic          m0_rvalid;
   logic          m1_gnt;
   logic          m1_rvalid;
   logic          busy;
   logic [DW-1:0] rdata;

   int n_vec = 0;
   int n_err = 0;

   bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_addr   (m0_addr),
      .m0_kill   (m0_kill),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .rdata     (rdata),
      .busy      (busy),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   int gcnt;
   int ng;
   logic exp_m1;

   initial begin
      bus.a_ready = 1'b0;
      bus.d_valid = 1'b0;
      bus.d_data  = '0;

      // reset state
      cyc(); cyc();
      smp();
      check_val("rst_busy",    64'(busy),          64'd0);
      check_val("rst_a_valid", 64'(bus.a_valid),   64'd0);
      check_val("rst_d_ready", 64'(bus.d_ready),   64'd0);
      check_val("rst_gnt",     64'({m0_gnt, m1_gnt}), 64'd0);
      check_val("rst_rvalid",  64'({m0_rvalid, m1_rvalid}), 64'd0);
      check_val("rst_rdata",   rdata,              64'd0);
      check_val("rst_addr",    bus.a_address,      64'd0);

      // both masters request from reset; m0 wins the first tie
      cyc();
      rst_n = 1'b1;
      m0_req = 1'b1; m0_addr = 64'h8000_0000;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 64'h8000_1000; m1_wdata = 64'hDEAD_BEEF;
      bus.a_ready = 1'b1; bus.d_valid = 1'b1; bus.d_data = 64'h1234;
      smp();
      check_val("c0_busy", 64'(busy),   64'd0);
      check_val("c0_gnt",  64'(m0_gnt), 64'd0);
      cyc(); smp();
      check_val("c1_m0_gnt",  64'(m0_gnt),      64'd1);
      check_val("c1_m1_gnt",  64'(m1_gnt),      64'd0);
      check_val("c1_a_valid", 64'(bus.a_valid), 64'd1);
      check_val("c1_opcode",  64'(bus.a_opcode), 64'd4);
      check_val("c1_addr",    bus.a_address,    64'h8000_0000);
      check_val("c1_data",    bus.a_data,       64'd0);
      check_val("c1_d_ready", 64'(bus.d_ready), 64'd0);
      cyc(); m0_req = 1'b0; smp();
      check_val("c2_d_ready", 64'(bus.d_ready), 64'd1);
      check_val("c2_a_valid", 64'(bus.a_valid), 64'd0);
      check_val("c2_rvalid",  64'(m0_rvalid),   64'd0);
      cyc(); bus.d_data = 64'h55; smp();
      check_val("c3_m0_rvalid", 64'(m0_rvalid), 64'd1);
      check_val("c3_rdata",     rdata,          64'h1234);
      check_val("c3_busy",      64'(busy),      64'd0);
      check_val("c3_m1_gnt",    64'(m1_gnt),    64'd0);
      cyc(); smp();
      check_val("c4_m1_gnt",  64'(m1_gnt),       64'd1);
      check_val("c4_m0_gnt",  64'(m0_gnt),       64'd0);
      check_val("c4_opcode",  64'(bus.a_opcode), 64'd0);
      check_val("c4_addr",    bus.a_address,     64'h8000_1000);
      check_val("c4_data",    bus.a_data,        64'hDEAD_BEEF);
      cyc(); m1_req = 1'b0; smp();
      check_val("c5_m1_rvalid", 64'(m1_rvalid), 64'd0);
      cyc(); smp();
      check_val("c6_m1_rvalid", 64'(m1_rvalid), 64'd1);
      check_val("c6_m0_rvalid", 64'(m0_rvalid), 64'd0);
      check_val("c6_rdata",     rdata,          64'h55);

      // A-channel back-pressure: 5 cycles of a_ready = 0
      cyc(); m0_req = 1'b1; m0_addr = 64'h100; m1_we = 1'b0; bus.a_ready = 1'b0; smp();
      gcnt = 0;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         if (i == 6) bus.a_ready = 1'b1;
         smp();
         gcnt += int'(m0_gnt);
         check_val("bp_a_valid", 64'(bus.a_valid), 64'd1);
         check_val("bp_addr",    bus.a_address,    64'h100);
         check_val("bp_gnt",     64'(m0_gnt),      (i == 6) ? 64'd1 : 64'd0);
      end
      check_val("bp_gnt_count", 64'(gcnt), 64'd1);
      cyc(); m0_req = 1'b0; smp();
      cyc(); smp();
      check_val("bp_rvalid", 64'(m0_rvalid), 64'd1);

      // kill during m0 RESP with a late D beat
      cyc(); m0_req = 1'b1; m0_addr = 64'h200; bus.d_valid = 1'b0; smp();
      cyc(); smp();
      check_val("k_gnt", 64'(m0_gnt), 64'd1);
      cyc(); m0_req = 1'b0; m0_kill = 1'b1; smp();
      check_val("k_d_ready0", 64'(bus.d_ready), 64'd1);
      cyc(); m0_kill = 1'b0; bus.d_valid = 1'b1; bus.d_data = 64'h77; smp();
      check_val("k_d_ready1", 64'(bus.d_ready), 64'd1);
      cyc(); m0_kill = 1'b1; m0_req = 1'b1; m0_addr = 64'h300; smp();
      check_val("k_rvalid", 64'(m0_rvalid), 64'd0);
      check_val("k_busy",   64'(busy),      64'd0);
      check_val("k_rdata",  rdata,          64'h77);
      cyc(); m0_kill = 1'b0; smp();
      check_val("k2_gnt",  64'(m0_gnt),  64'd1);
      check_val("k2_addr", bus.a_address, 64'h300);
      cyc(); m0_req = 1'b0; bus.d_data = 64'h88; smp();
      cyc(); smp();
      check_val("k2_rvalid", 64'(m0_rvalid), 64'd1);
      check_val("k2_rdata",  rdata,          64'h88);

      // kill while m1 owns the bus has no effect
      cyc(); m1_req = 1'b1; m1_we = 1'b0; m1_addr = 64'h400; smp();
      cyc(); smp();
      check_val("k1_gnt", 64'(m1_gnt), 64'd1);
      check_val("k1_op",  64'(bus.a_opcode), 64'd4);
      cyc(); m1_req = 1'b0; m0_kill = 1'b1; bus.d_data = 64'h99; smp();
      cyc(); m0_kill = 1'b0; smp();
      check_val("k1_rvalid", 64'(m1_rvalid), 64'd1);
      check_val("k1_rdata",  rdata,          64'h99);

      // reset asserted during RESP
      cyc(); m0_req = 1'b1; m0_addr = 64'h500; bus.d_valid = 1'b0; smp();
      cyc(); smp();
      check_val("r_gnt", 64'(m0_gnt), 64'd1);
      cyc(); m0_req = 1'b0; smp();
      check_val("r_busy_pre", 64'(busy), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check_val("r_busy",    64'(busy),        64'd0);
      check_val("r_d_ready", 64'(bus.d_ready), 64'd0);
      check_val("r_a_valid", 64'(bus.a_valid), 64'd0);
      check_val("r_rdata",   rdata,            64'd0);
      check_val("r_addr",    bus.a_address,    64'd0);
      cyc(); cyc();
      rst_n = 1'b1; bus.d_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         smp();
         check_val("r_no_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
         check_val("r_idle",      64'(busy),                   64'd0);
         cyc();
      end

      // continuous dual requests: grants alternate starting with m0
      m0_req = 1'b1; m0_addr = 64'h600;
      m1_req = 1'b1; m1_addr = 64'h700; m1_we = 1'b0;
      ng = 0;
      exp_m1 = 1'b0;
      for (int c = 0; c < 40 && ng < 10; c++) begin
         smp();
         check_val("rr_overlap", 64'(bus.a_valid & bus.d_ready), 64'd0);
         if (m0_gnt || m1_gnt) begin
            check_val("rr_gnt", 64'({m0_gnt, m1_gnt}), exp_m1 ? 64'd1 : 64'd2);
            exp_m1 = ~exp_m1;
            ng++;
         end
         cyc();
      end
      check_val("rr_count", 64'(ng), 64'd10);
      m0_req = 1'b0; m1_req = 1'b0;
      cyc(); cyc(); cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
